// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Multi-port register file with registered reads and a hardware
//            clear sequencer that zeroes one entry per cycle after reset/CLR.
//            Optional macro REG_FILE_BYPASS_EN forwards same-edge write data.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
   parameter int BITS     = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR     = 4,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WR_PORTS-1:0]      WE,
   input  logic [WR_PORTS*ADDR-1:0] WA,
   input  logic [WR_PORTS*BITS-1:0] WD,
   input  logic [RD_PORTS-1:0]      RE,
   input  logic [RD_PORTS*ADDR-1:0] RA,
   output logic [RD_PORTS*BITS-1:0] RD,
   output logic [RD_PORTS-1:0]      RD_VALID,
   input  logic                     CLR,
   output logic                     BUSY,
   output logic                     WR_COLL
);

   localparam logic [ADDR:0]   c_DEPTH = (ADDR+1)'(DEPTH);
   localparam logic [ADDR-1:0] c_LAST  = ADDR'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR-1:0]          cnt_q, cnt_d;
   logic [BITS-1:0]          mem_q [DEPTH];
   logic [RD_PORTS*BITS-1:0] rd_q, rd_d;
   logic [RD_PORTS-1:0]      rd_valid_q, rd_valid_d;
   logic                     wr_coll_q, wr_coll_d;
   logic                     w_idle;

   function automatic logic in_range(input logic [ADDR-1:0] a);
      return {1'b0, a} < c_DEPTH;
   endfunction

   assign w_idle = (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (CLR) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + ADDR'(1);
            if (cnt_q == c_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // The array has no reset; the sequencer zeroes it after every reset instead.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int p = 0; p < WR_PORTS; p++) begin
            if (WE[p] && in_range(WA[p*ADDR +: ADDR]))
               mem_q[WA[p*ADDR +: ADDR]] <= WD[p*BITS +: BITS];
         end
      end
   end

   always_comb begin
      rd_d       = rd_q;
      rd_valid_d = '0;
      if (w_idle) begin
         for (int r = 0; r < RD_PORTS; r++) begin
            if (RE[r]) begin
               rd_valid_d[r]        = 1'b1;
               rd_d[r*BITS +: BITS] = '0;
               if (in_range(RA[r*ADDR +: ADDR])) begin
                  rd_d[r*BITS +: BITS] = mem_q[RA[r*ADDR +: ADDR]];
`ifdef REG_FILE_BYPASS_EN
                  // Ascending scan so the highest-indexed writer wins, matching the array.
                  for (int p = 0; p < WR_PORTS; p++) begin
                     if (WE[p] && (WA[p*ADDR +: ADDR] == RA[r*ADDR +: ADDR]))
                        rd_d[r*BITS +: BITS] = WD[p*BITS +: BITS];
                  end
`endif
               end
            end
         end
      end
   end

   generate
      if (WR_PORTS > 1) begin : g_coll
         assign wr_coll_d = w_idle & WE[0] & WE[1] &
                            (WA[0 +: ADDR] == WA[ADDR +: ADDR]);
      end else begin : g_no_coll
         assign wr_coll_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         cnt_q      <= '0;
         rd_q       <= '0;
         rd_valid_q <= '0;
         wr_coll_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         wr_coll_q  <= wr_coll_d;
      end
   end

   assign RD       = rd_q;
   assign RD_VALID = rd_valid_q;
   assign BUSY     = (state_q == S_CLEAR);
   assign WR_COLL  = wr_coll_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp: behavioural model compared
//            every cycle, plus directed literal checks (DEPTH=16 and DEPTH=12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  we = '0, re = '0;
   logic [7:0]  wa = '0, ra = '0;
   logic [15:0] wd = '0;
   logic        clr = 1'b0;
   logic [15:0] rd;
   logic [1:0]  rd_vld;
   logic        busy, coll;

   logic [1:0]  b_we = '0, b_re = '0;
   logic [7:0]  b_wa = '0, b_ra = '0;
   logic [15:0] b_wd = '0;
   logic        b_clr = 1'b0;
   logic [15:0] b_rd;
   logic [1:0]  b_vld;
   logic        b_busy, b_coll;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   reg_file_mp dut (
      .clk(clk), .rst(rst), .WE(we), .WA(wa), .WD(wd), .RE(re), .RA(ra),
      .RD(rd), .RD_VALID(rd_vld), .CLR(clr), .BUSY(busy), .WR_COLL(coll)
   );

   reg_file_mp #(.BITS(8), .DEPTH(12), .ADDR(4), .RD_PORTS(2), .WR_PORTS(2)) dut12 (
      .clk(clk), .rst(rst), .WE(b_we), .WA(b_wa), .WD(b_wd), .RE(b_re), .RA(b_ra),
      .RD(b_rd), .RD_VALID(b_vld), .CLR(b_clr), .BUSY(b_busy), .WR_COLL(b_coll)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the array as plain storage, a busy flag and a clear index.
   logic [7:0]  m_mem [DEPTH];
   bit          m_busy;
   int          m_idx;
   logic [15:0] e_rd;
   logic [1:0]  e_vld;
   logic        e_coll;

   task automatic model_reads();
      int a;
      for (int r = 0; r < 2; r++) begin
         if (re[r]) begin
            a = int'(ra[r*4 +: 4]);
            e_rd[r*8 +: 8] = (a < DEPTH) ? m_mem[a] : 8'h00;
            e_vld[r] = 1'b1;
         end else begin
            e_vld[r] = 1'b0;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b1; m_idx = 0; e_rd = '0; e_vld = '0; e_coll = 1'b0;
      end else if (m_busy) begin
         m_mem[m_idx] = 8'h00;
         m_idx++;
         if (m_idx == DEPTH) m_busy = 1'b0;
         e_vld = '0; e_coll = 1'b0;
      end else begin
         e_coll = (we == 2'b11) && (wa[3:0] == wa[7:4]);
`ifndef REG_FILE_BYPASS_EN
         model_reads();
`endif
         for (int p = 0; p < 2; p++)
            if (we[p]) m_mem[int'(wa[p*4 +: 4])] = wd[p*8 +: 8];
`ifdef REG_FILE_BYPASS_EN
         model_reads();
`endif
         if (clr) begin m_busy = 1'b1; m_idx = 0; end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("m_busy",  32'(busy),   32'(m_busy));
         chk("m_rdvld", 32'(rd_vld), 32'(e_vld));
         chk("m_coll",  32'(coll),   32'(e_coll));
         chk("m_rd",    32'(rd),     32'(e_rd));
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      logic [7:0] exp_rdw;
      re = 2'b11;
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'(1));
      chk("rst_rd",   32'(rd),   32'(0));
      chk("rst_vld",  32'(rd_vld), 32'(0));
      chk("rst_coll", 32'(coll), 32'(0));
      #2 rst = 1'b0;
      repeat (5) @(negedge clk);
      // Reset mid-clear must restart the sequence from entry 0.
      #2 rst = 1'b1;
      #1 chk("rst2_busy", 32'(busy), 32'(1));
      chk("rst2_vld", 32'(rd_vld), 32'(0));
      @(negedge clk);
      #2 rst = 1'b0;
      cnt = 1;
      @(negedge clk);
      while (busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk("rst_busy_len", 32'(cnt), 32'(16));
      for (int a = 0; a < 8; a++) begin
         ra = {4'(a + 8), 4'(a)};
         @(negedge clk);
         chk("post_clr_rd", 32'(rd), 32'(0));
         chk("post_clr_vld", 32'(rd_vld), 32'(2'b11));
      end

      re = 2'b00;
      we = 2'b11; wa = {4'd7, 4'd3}; wd = {8'h3C, 8'hA5};
      @(negedge clk);
      we = 2'b00; re = 2'b11; ra = {4'd7, 4'd3};
      @(negedge clk);
      chk("dual_rd", 32'(rd), 32'(16'h3CA5));
      chk("dual_vld", 32'(rd_vld), 32'(2'b11));

      re = 2'b00;
      we = 2'b11; wa = {4'd5, 4'd5}; wd = {8'h22, 8'h11};
      @(negedge clk);
      chk("coll_pulse", 32'(coll), 32'(1));
      we = 2'b00; re = 2'b01; ra = {4'd0, 4'd5};
      @(negedge clk);
      chk("coll_once", 32'(coll), 32'(0));
      chk("coll_win", 32'(rd[7:0]), 32'(8'h22));

      re = 2'b00; we = 2'b01; wa = {4'd0, 4'd9}; wd = {8'h00, 8'h55};
      @(negedge clk);
      wd = {8'h00, 8'h99}; re = 2'b01; ra = {4'd0, 4'd9};
      @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
      exp_rdw = 8'h99;
`else
      exp_rdw = 8'h55;
`endif
      chk("rdw_same_edge", 32'(rd[7:0]), 32'(exp_rdw));
      we = 2'b00;
      @(negedge clk);
      chk("rdw_after", 32'(rd[7:0]), 32'(8'h99));

      re = 2'b00;
      for (int a = 0; a < 8; a++) begin
         we = 2'b11; wa = {4'(a + 8), 4'(a)}; wd = 16'hFFFF;
         @(negedge clk);
      end
      we = 2'b00; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0; cnt = 0; wa = {4'd0, 4'd2}; wd = {8'h00, 8'hAB};
      while (busy && cnt < 40) begin
         cnt++;
         clr = (cnt == 4);
         we  = (cnt == 6) ? 2'b01 : 2'b00;
         @(negedge clk);
      end
      clr = 1'b0; we = 2'b00;
      chk("clr_busy_len", 32'(cnt), 32'(16));
      re = 2'b11;
      for (int a = 0; a < 8; a++) begin
         ra = {4'(a + 8), 4'(a)};
         @(negedge clk);
         chk("clr_all_zero", 32'(rd), 32'(0));
      end

      for (int i = 0; i < 400; i++) begin
         we = 2'($urandom_range(0, 3));
         wa[3:0] = 4'($urandom_range(0, 15));
         wa[7:4] = ($urandom_range(0, 5) == 0) ? wa[3:0] : 4'($urandom_range(0, 15));
         wd = 16'($urandom);
         re = 2'($urandom_range(0, 3));
         ra = 8'($urandom);
         clr = ($urandom_range(0, 59) == 0);
         @(negedge clk);
      end
      we = 2'b00; re = 2'b00; clr = 1'b0;

      chk("d12_idle", 32'(b_busy), 32'(0));
      for (int a = 0; a < 12; a += 2) begin
         b_we = 2'b11; b_wa = {4'(a + 1), 4'(a)};
         b_wd = {8'(8'h40 + a + 1), 8'(8'h40 + a)};
         @(negedge clk);
      end
      b_we = 2'b11; b_wa = {4'd14, 4'd13}; b_wd = {8'h66, 8'h77};
      @(negedge clk);
      b_we = 2'b00; b_re = 2'b11; b_ra = {4'd0, 4'd5};
      @(negedge clk);
      chk("d12_pre", 32'(b_rd), 32'(16'h4045));
      b_ra = {4'd1, 4'd13};
      @(negedge clk);
      chk("d12_oor_rd", 32'(b_rd), 32'(16'h4100));
      chk("d12_oor_vld", 32'(b_vld), 32'(2'b11));
      for (int a = 0; a < 12; a += 2) begin
         b_ra = {4'(a + 1), 4'(a)};
         @(negedge clk);
         chk("d12_keep", 32'(b_rd), 32'({8'(8'h40 + a + 1), 8'(8'h40 + a)}));
      end
      b_re = 2'b00;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file: WR_PORTS write ports, RD_PORTS registered read ports, and a hardware clear sequencer. It replaces the single-write/dual-read register file in datapaths that need concurrent writebacks and more operand reads. After reset and on request, it clears itself one entry per cycle, so no wide async reset of the array is needed.

Parameters:
BITS, 8, data width per entry
DEPTH, 16, number of entries (2 to 2**ADDR)
ADDR, 4, address width
RD_PORTS, 2, number of read ports (1 to 4)
WR_PORTS, 2, number of write ports (1 to 2)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous reset, active-high
WE  in  WR_PORTS  per-port write enable
WA  in  WR_PORTS*ADDR  write addresses; port p at [p*ADDR +: ADDR]
WD  in  WR_PORTS*BITS  write data; port p at [p*BITS +: BITS]
RE  in  RD_PORTS  per-port read enable
RA  in  RD_PORTS*ADDR  read addresses, packed as WA
RD  out  RD_PORTS*BITS  registered read data, packed as WD
RD_VALID  out  RD_PORTS  per-port pulse: RD updated this cycle
CLR  in  1  clear request, single-cycle pulse
BUSY  out  1  clear sequence in progress
WR_COLL  out  1  pulse: two ports wrote the same address in one cycle

Behaviour:
- Reset (async, rst=1):
  - RD=0, RD_VALID=0, WR_COLL=0, BUSY=1.
  - Clear counter=0, FSM=CLEAR.
  - Array contents are not reset directly.
- FSM states:
  - IDLE: BUSY=0. CLR=1 -> CLEAR, counter=0, BUSY=1 from the next cycle.
  - CLEAR: BUSY=1. Write entry[counter]=0 and increment each cycle.
  - CLEAR -> IDLE after writing entry DEPTH-1. The sequence takes exactly DEPTH cycles.
  - CLR during CLEAR is ignored and does not restart the sequence.
  - rst during CLEAR restarts the sequence at entry 0.
- Writes, IDLE only:
  - On the rising edge, entry[WA_p] <= WD_p for each p with WE_p=1.
  - WE is ignored while BUSY=1.
  - Write address >= DEPTH: that port's write is dropped.
- Write collision (both ports enabled, same address, IDLE):
  - Highest-indexed port wins.
  - WR_COLL=1 for one cycle, registered, the cycle after the edge.
- Reads:
  - Latency 1: RE_r=1 at edge N gives RD_r = entry[RA_r] and RD_VALID_r=1 after edge N.
  - RE_r=0: RD_r holds its last value and RD_VALID_r=0.
  - Reads during BUSY=1: RD holds, RD_VALID=0.
  - Read address >= DEPTH returns 0 with RD_VALID=1.
- Read-during-write, same address, same edge:
  - Without the macro, RD returns the old entry value.
  - With bypass, see Optional Feature.
- Multiple read ports on the same address are legal and independent.
- No combinational path from any input to any output.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: a read that hits an address being written on the same edge returns the new write data.
  - On a collision, the bypass returns the winning (highest-indexed) port's data.
  - Bypass is inactive while BUSY=1.
- Undefined: read-old-data semantics as in Behaviour; no bypass muxes are instantiated.

Test Plan:
(Defaults: BITS=8, DEPTH=16, ADDR=4, RD_PORTS=2, WR_PORTS=2.)
1. Reset:
   - Stimulus: assert rst mid-cycle, release; hold RE=2'b11 throughout.
   - Response: BUSY=1 for exactly 16 cycles after release, then 0. RD_VALID=0 while busy. First post-clear reads of addresses 0..15 return 8'h00.
2. Dual write, then read:
   - Stimulus: WE=2'b11, WA0=3, WD0=8'hA5, WA1=7, WD1=8'h3C. Next cycle RA0=3, RA1=7, RE=2'b11.
   - Response: one cycle later, RD0=8'hA5, RD1=8'h3C, RD_VALID=2'b11.
3. Collision:
   - Stimulus: WA0=WA1=5, WD0=8'h11, WD1=8'h22, WE=2'b11.
   - Response: WR_COLL pulses once. A subsequent read of 5 returns 8'h22.
4. Read-during-write:
   - Stimulus: entry 9 holds 8'h55. Write 8'h99 to 9 while RA0=9, RE0=1 on the same edge.
   - Response: RD0=8'h55 without REG_FILE_BYPASS_EN; RD0=8'h99 with it.
5. Clear while busy:
   - Stimulus: fill all entries with 8'hFF, pulse CLR. Pulse CLR again at clear cycle 4, and issue WE to address 2 at clear cycle 6.
   - Response: BUSY lasts exactly 16 cycles. All entries read 8'h00 afterwards, including address 2.
6. Out-of-range address:
   - Stimulus: instance with DEPTH=12. Write 8'h77 to address 13, then read address 13.
   - Response: RD=8'h00, RD_VALID=1. Entries 0..11 are unchanged.
